// File: rtl/screen_pkg.sv
// Shared screen stream layout, digit cell geometry and 7-segment decode.
// Used by score_number and bcd_digit_cell.
package screen_pkg;

  localparam int HS     = 25;
  localparam int VS     = 24;
  localparam int AV     = 23;
  localparam int X_HI   = 22;
  localparam int X_LO   = 13;
  localparam int Y_HI   = 12;
  localparam int Y_LO   = 3;
  localparam int RGB_HI = 2;
  localparam int RGB_LO = 0;

  localparam int CELL_W   = 3;
  localparam int CELL_H   = 5;
  localparam int CELL_GAP = 1;

  // BCD -> segments, bit 6 = a ... bit 0 = g
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // True when cell (cx,cy) belongs to a lit segment of s
  function automatic logic seg_hit(
    input logic [6:0]  s,
    input logic [10:0] cx,
    input logic [10:0] cy
  );
    logic top, bot, l, r;
    top = cy <= 11'd2;
    bot = cy >= 11'd2;
    l   = cx == 11'd0;
    r   = cx == 11'd2;
    return (s[6] & (cy == 11'd0))
         | (s[3] & (cy == 11'd4))
         | (s[0] & (cy == 11'd2))
         | (s[1] & l & top)
         | (s[5] & r & top)
         | (s[2] & l & bot)
         | (s[4] & r & bot);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with load, step up/down and ripple outputs.
// up_out/dn_out request a step of the next more-significant digit.
module bcd_digit_cell
  import screen_pkg::*;
(
  input  logic       px_clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [3:0] ld_digit,
  input  logic       up,
  input  logic       dn,
  output logic [3:0] digit,
  output logic       up_out,
  output logic       dn_out
);

  assign up_out = up & (digit == 4'd9);
  assign dn_out = dn & (digit == 4'd0);

  // digit register: load clamps to 9, steps wrap within 0..9
  always_ff @(posedge px_clk) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (ld) begin
      digit <= (ld_digit > 4'd9) ? 4'd9 : ld_digit;
    end else if (up) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end else if (dn) begin
      digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/score_number.sv
// N-digit BCD up/down counter with a frame-latched 7-segment overlay.
// Define SCORE_NUMBER_ZERO_BLANK_EN to suppress leading zero digits.
module score_number
  import screen_pkg::*;
#(
  parameter logic [2:0] COLOR      = 3'b111,
  parameter int         DIGITS     = 2,
  parameter int         SCALE_LOG2 = 2,
  parameter int         SATURATE   = 0
) (
  input  logic                  px_clk,
  input  logic                  reset,
  input  logic [25:0]           strRGB_i,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry,
  output logic                  borrow,
  output logic [25:0]           strRGB_o
);

  localparam int U     = 1 << SCALE_LOG2;
  localparam int PITCH = (CELL_W + CELL_GAP) * U;
  localparam logic [10:0] BOX_W = 11'(CELL_W * U);
  localparam logic [10:0] BOX_H = 11'(CELL_H * U);

  logic inc_q, dec_q, vs_q;
  logic inc_evt, dec_evt;
  logic inc_step, dec_step;
  logic all9, all0;
  logic inc_go, dec_go;
  logic carry_d, borrow_d;
  logic [DIGITS:0] up_c, dn_c;
  logic [4*DIGITS-1:0] shadow;
  logic lit;

  assign inc_evt  = inc & ~inc_q;
  assign dec_evt  = dec & ~dec_q;
  assign inc_step = ~load & inc_evt & ~dec_evt;
  assign dec_step = ~load & dec_evt & ~inc_evt;

  // bound detection across all digits
  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9 = all9 & (value[4*i +: 4] == 4'd9);
      all0 = all0 & (value[4*i +: 4] == 4'd0);
    end
  end

  assign inc_go = inc_step & ~((SATURATE != 0) & all9);
  assign dec_go = dec_step & ~((SATURATE != 0) & all0);
  assign up_c[0] = inc_go;
  assign dn_c[0] = dec_go;

  assign carry_d  = (SATURATE != 0) ? (inc_step & all9)
                                    : up_c[DIGITS];
  assign borrow_d = (SATURATE != 0) ? (dec_step & all0)
                                    : dn_c[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_cell u_cell (
      .px_clk   (px_clk),
      .reset    (reset),
      .ld       (load),
      .ld_digit (load_value[4*i +: 4]),
      .up       (up_c[i]),
      .dn       (dn_c[i]),
      .digit    (value[4*i +: 4]),
      .up_out   (up_c[i+1]),
      .dn_out   (dn_c[i+1])
    );
  end

  // edge registers, pulses and frame-synchronous shadow copy
  always_ff @(posedge px_clk) begin
    if (!reset) begin
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      vs_q   <= 1'b0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      shadow <= '0;
    end else begin
      inc_q  <= inc;
      dec_q  <= dec;
      vs_q   <= strRGB_i[VS];
      carry  <= carry_d;
      borrow <= borrow_d;
      if (strRGB_i[VS] && !vs_q) begin
        shadow <= value;
      end
    end
  end

  logic [10:0] px, py, ox, oy, dx, dy, cx, cy;
  logic [3:0]  d;
  logic [6:0]  s;
  logic        inbox, show;
`ifdef SCORE_NUMBER_ZERO_BLANK_EN
  logic        lead;
`endif

  // pixel hit test against every digit box
  always_comb begin
    lit   = 1'b0;
    d     = '0;
    s     = '0;
    ox    = '0;
    dx    = '0;
    dy    = '0;
    cx    = '0;
    cy    = '0;
    inbox = 1'b0;
    show  = 1'b0;
    px    = {1'b0, strRGB_i[X_HI:X_LO]};
    py    = {1'b0, strRGB_i[Y_HI:Y_LO]};
    oy    = {1'b0, pos_y};
`ifdef SCORE_NUMBER_ZERO_BLANK_EN
    lead  = 1'b0;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      d = shadow[4*(DIGITS-1-k) +: 4];
`ifdef SCORE_NUMBER_ZERO_BLANK_EN
      lead = lead | (d != 4'd0);
      show = lead | (k == DIGITS - 1);
`else
      show = 1'b1;
`endif
      ox = {1'b0, pos_x} + 11'(PITCH * k);
      inbox = (px >= ox) && (px < ox + BOX_W)
           && (py >= oy) && (py < oy + BOX_H);
      dx = px - ox;
      dy = py - oy;
      cx = dx >> SCALE_LOG2;
      cy = dy >> SCALE_LOG2;
      s  = seg7(d);
      if (inbox && show && seg_hit(s, cx, cy)) begin
        lit = 1'b1;
      end
    end
  end

  // registered stream output, colour substituted on lit active pixels
  always_ff @(posedge px_clk) begin
    if (!reset) begin
      strRGB_o <= '0;
    end else begin
      strRGB_o[HS:Y_LO] <= strRGB_i[HS:Y_LO];
      strRGB_o[RGB_HI:RGB_LO] <= (strRGB_i[AV] && lit)
                               ? COLOR
                               : strRGB_i[RGB_HI:RGB_LO];
    end
  end

endmodule

// File: tb/tb_score_number.sv
// Bench for score_number: wrap and saturate instances side by side,
// checked every cycle against an integer/glyph model.
module tb_score_number;

  logic        px_clk = 1'b0;
  logic        reset;
  logic [25:0] strRGB_i;
  logic [9:0]  pos_x, pos_y;
  logic        inc, dec, load;
  logic [7:0]  load_value;
  logic [7:0]  value0, value1;
  logic        carry0, carry1, borrow0, borrow1;
  logic [25:0] rgb_o0, rgb_o1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 px_clk = ~px_clk;

  score_number #(.COLOR(3'b111), .DIGITS(2), .SCALE_LOG2(2), .SATURATE(0)) u_wrap (
    .px_clk(px_clk), .reset(reset), .strRGB_i(strRGB_i),
    .pos_x(pos_x), .pos_y(pos_y), .inc(inc), .dec(dec),
    .load(load), .load_value(load_value), .value(value0),
    .carry(carry0), .borrow(borrow0), .strRGB_o(rgb_o0)
  );

  score_number #(.COLOR(3'b010), .DIGITS(2), .SCALE_LOG2(2), .SATURATE(1)) u_sat (
    .px_clk(px_clk), .reset(reset), .strRGB_i(strRGB_i),
    .pos_x(pos_x), .pos_y(pos_y), .inc(inc), .dec(dec),
    .load(load), .load_value(load_value), .value(value1),
    .carry(carry1), .borrow(borrow1), .strRGB_o(rgb_o1)
  );

  // 3x5 glyphs, row-major, top row in bits 14:12
  logic [14:0] glyph [10] = '{
    15'b111_101_101_101_111, 15'b001_001_001_001_001,
    15'b111_001_111_100_111, 15'b111_001_111_001_111,
    15'b101_101_111_001_001, 15'b111_100_111_001_111,
    15'b111_100_111_101_111, 15'b111_001_001_001_001,
    15'b111_101_111_101_111, 15'b111_101_111_001_111
  };

  function automatic logic [25:0] mk(bit vs, bit av, int x, int y, logic [2:0] c);
    logic [9:0] xx, yy;
    xx = 10'(x);
    yy = 10'(y);
    return {1'b0, vs, av, xx, yy, c};
  endfunction

  function automatic bit model_lit(int x, int y, int ox0, int oy, int sh);
    for (int k = 0; k < 2; k++) begin
      int ox, dig, cx, cy;
      bit show;
      ox = ox0 + 16 * k;
      if (x >= ox && x < ox + 12 && y >= oy && y < oy + 20) begin
        dig = (k == 0) ? sh / 10 : sh % 10;
        show = 1;
`ifdef SCORE_NUMBER_ZERO_BLANK_EN
        if (k == 0 && sh < 10) show = 0;
`endif
        cx = (x - ox) / 4;
        cy = (y - oy) / 4;
        if (show && glyph[dig][14 - (cy * 3 + cx)]) return 1;
      end
    end
    return 0;
  endfunction

  function automatic int clampd(logic [3:0] n);
    return (n > 9) ? 9 : int'(n);
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  int mv [2], msh [2];
  bit mc [2], mb [2];
  logic [25:0] mo [2];
  logic [2:0] col [2] = '{3'b111, 3'b010};
  bit pinc, pdec, pvs;

  // reference model: integer count, glyph render, frame latch
  always @(posedge px_clk) begin
    bit ie, de, rise;
    ie = inc & ~pinc;
    de = dec & ~pdec;
    rise = strRGB_i[24] & ~pvs;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        mv[i] = 0; msh[i] = 0; mc[i] = 0; mb[i] = 0; mo[i] = '0;
      end else begin
        mo[i] = strRGB_i;
        if (strRGB_i[23] && model_lit(int'(strRGB_i[22:13]), int'(strRGB_i[12:3]),
                                      int'(pos_x), int'(pos_y), msh[i]))
          mo[i][2:0] = col[i];
        if (rise) msh[i] = mv[i];
        mc[i] = 0;
        mb[i] = 0;
        if (load) begin
          mv[i] = clampd(load_value[7:4]) * 10 + clampd(load_value[3:0]);
        end else if (ie && !de) begin
          if (mv[i] == 99) begin
            mc[i] = 1;
            mv[i] = (i == 1) ? 99 : 0;
          end else mv[i] = mv[i] + 1;
        end else if (de && !ie) begin
          if (mv[i] == 0) begin
            mb[i] = 1;
            mv[i] = (i == 1) ? 0 : 99;
          end else mv[i] = mv[i] - 1;
        end
      end
    end
    pinc = reset ? inc : 1'b0;
    pdec = reset ? dec : 1'b0;
    pvs  = reset ? strRGB_i[24] : 1'b0;
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge px_clk) begin
    if (chk_en) begin
      chk("wrap.value", 32'(value0), 32'(to_bcd(mv[0])));
      chk("wrap.carry", 32'(carry0), 32'(mc[0]));
      chk("wrap.borrow", 32'(borrow0), 32'(mb[0]));
      chk("wrap.rgb_o", 32'(rgb_o0), 32'(mo[0]));
      chk("sat.value", 32'(value1), 32'(to_bcd(mv[1])));
      chk("sat.carry", 32'(carry1), 32'(mc[1]));
      chk("sat.borrow", 32'(borrow1), 32'(mb[1]));
      chk("sat.rgb_o", 32'(rgb_o1), 32'(mo[1]));
    end
  end

  task automatic cyc();
    @(posedge px_clk);
    #1;
  endtask

  task automatic pix(int x, int y, bit av);
    strRGB_i = mk(0, av, x, y, 3'b001);
    cyc();
  endtask

  task automatic vsync_pulse();
    strRGB_i = mk(1, 0, 600, 600, 3'b000);
    cyc();
    strRGB_i = mk(0, 0, 600, 600, 3'b000);
    cyc();
  endtask

  initial begin
    reset = 0; inc = 0; dec = 0; load = 0; load_value = '0;
    pos_x = 10'd100; pos_y = 10'd50;
    strRGB_i = mk(0, 1, 500, 500, 3'b011);
    cyc();
    chk_en = 1;
    cyc(); cyc();
    reset = 1;
    cyc();
    @(negedge px_clk);
    chk("lit.reset_value", 32'(value0), 32'h0);
    chk("lit.reset_carry", 32'(carry0), 32'h0);
    chk("lit.passthru", 32'(rgb_o0), 32'(mk(0, 1, 500, 500, 3'b011)));

    load = 1; load_value = 8'h98; cyc(); load = 0;
    @(negedge px_clk);
    chk("lit.load98", 32'(value0), 32'h98);
    inc = 1; cyc(); inc = 0;
    @(negedge px_clk);
    chk("lit.inc99", 32'(value0), 32'h99);
    cyc();
    inc = 1; cyc();
    @(negedge px_clk);
    chk("lit.wrap00", 32'(value0), 32'h00);
    chk("lit.carry_pulse", 32'(carry0), 32'h1);
    inc = 0; cyc();
    @(negedge px_clk);
    chk("lit.carry_drop", 32'(carry0), 32'h0);
    dec = 1; cyc();
    @(negedge px_clk);
    chk("lit.dec_wrap99", 32'(value0), 32'h99);
    chk("lit.borrow_pulse", 32'(borrow0), 32'h1);
    dec = 0; cyc();

    load = 1; load_value = 8'h99; cyc(); load = 0;
    inc = 1; cyc();
    @(negedge px_clk);
    chk("lit.sat_hold99", 32'(value1), 32'h99);
    chk("lit.sat_carry", 32'(carry1), 32'h1);
    inc = 0; cyc();
    load = 1; load_value = 8'h00; cyc(); load = 0;
    dec = 1; cyc();
    @(negedge px_clk);
    chk("lit.sat_hold00", 32'(value1), 32'h00);
    chk("lit.sat_borrow", 32'(borrow1), 32'h1);
    dec = 0; cyc();

    load = 1; load_value = 8'h4F; inc = 1; cyc();
    load = 0; inc = 0;
    @(negedge px_clk);
    chk("lit.load_clamp", 32'(value0), 32'h49);
    cyc();
    inc = 1; dec = 1; cyc();
    @(negedge px_clk);
    chk("lit.both_edges", 32'(value0), 32'h49);
    chk("lit.both_nocarry", 32'(carry0), 32'h0);
    inc = 0; dec = 0; cyc();

    load = 1; load_value = 8'h01; cyc(); load = 0;
    vsync_pulse();
    for (int y = 48; y < 72; y++)
      for (int x = 96; x < 134; x++) pix(x, y, 1);
    pix(124, 54, 1);
    @(negedge px_clk);
    chk("lit.lsd_seg_b", 32'(rgb_o0[2:0]), 32'h7);
    pix(116, 58, 1);
    @(negedge px_clk);
    chk("lit.lsd_unlit", 32'(rgb_o0[2:0]), 32'h1);
    pix(124, 54, 0);
    @(negedge px_clk);
    chk("lit.inactive", 32'(rgb_o0[2:0]), 32'h1);

    load = 1; load_value = 8'h88; cyc(); load = 0;
    pix(116, 58, 1);
    @(negedge px_clk);
    chk("lit.frame_hold", 32'(rgb_o0[2:0]), 32'h1);
    vsync_pulse();
    pix(116, 58, 1);
    @(negedge px_clk);
    chk("lit.frame_new", 32'(rgb_o0[2:0]), 32'h7);
    for (int y = 48; y < 72; y++)
      for (int x = 96; x < 134; x++) pix(x, y, 1);

    pos_x = 10'd1020; pos_y = 10'd1016;
    for (int y = 1012; y < 1028; y++)
      for (int x = 1014; x < 1030; x++) pix(x % 1024, y % 1024, 1);
    pix(1020, 1016, 1);
    @(negedge px_clk);
    chk("lit.clip_in", 32'(rgb_o0[2:0]), 32'h7);
    pix(0, 1016, 1);
    @(negedge px_clk);
    chk("lit.clip_nowrap", 32'(rgb_o0[2:0]), 32'h1);

    strRGB_i = mk(0, 1, 300, 300, 3'b101);
    reset = 0; cyc();
    @(negedge px_clk);
    chk("lit.midreset_rgb", 32'(rgb_o0), 32'h0);
    chk("lit.midreset_val", 32'(value0), 32'h0);
    reset = 1; cyc(); cyc();
    @(negedge px_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
